kbd_playback_ctrl: RTL and testbench

- Playback controller for the flash audio player. It decodes the same five ASCII keyboard commands as the keyboard interface: E play, D pause, F forward, B backward, R restart.
- It sequences 32-bit word reads from flash over an Avalon-style read handshake and emits one 16-bit sample per sample_tick.
- It sits between the keyboard decoder, the flash controller and the audio output stage.

---
 rtl/kbd_playback_ctrl.sv | 128 ++++++++++++
 tb/tb_kbd_playback_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_playback_ctrl.sv
// Keyboard-driven playback sequencer: fetches 32-bit flash words and plays each as two 16-bit samples, one per sample_tick.
// Latency: a command takes effect the cycle after its strobe. Flash stalls simply hold the FETCH state; ticks outside OUT states are dropped.
module kbd_playback_ctrl #(
    parameter int                ADDR_W    = 23,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        kbd_data,
    input  logic              kbd_valid,
    input  logic              sample_tick,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic              flash_waitrequest,
    input  logic [31:0]       flash_readdata,
    input  logic              flash_readdatavalid,
    output logic [15:0]       sample_out,
    output logic              sample_valid,
    output logic              playing,
    output logic              direction
);

    typedef enum logic [2:0] {
        FETCH,
        WAIT_DATA,
        OUT_FIRST,
        OUT_SECOND,
        ADVANCE
    } state_t;

    state_t            state;
    logic              restart_pending;
    logic [15:0]       first_half;
    logic [15:0]       second_half;
    logic [7:0]        key_uc;
    logic [ADDR_W-1:0] restart_addr;

    // Clearing bit 5 folds lowercase letters onto uppercase; no other code lands on E/D/F/B/R.
    assign key_uc       = kbd_data & 8'hDF;
    assign restart_addr = direction ? LAST_ADDR : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= FETCH;
            restart_pending <= 1'b0;
            playing         <= 1'b0;
            direction       <= 1'b0;
            flash_read      <= 1'b0;
            flash_addr      <= '0;
            sample_out      <= '0;
            sample_valid    <= 1'b0;
            first_half      <= '0;
            second_half     <= '0;
        end else begin
            sample_valid <= 1'b0;
            unique case (state)
                FETCH: begin
                    if (!flash_read) begin
                        flash_read <= 1'b1;
                    end else if (!flash_waitrequest) begin
                        flash_read <= 1'b0;
                        state      <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flash_readdatavalid) begin
                        if (restart_pending) begin
                            flash_addr      <= restart_addr;
                            restart_pending <= 1'b0;
                            state           <= FETCH;
                        end else begin
                            first_half  <= direction ? flash_readdata[31:16] : flash_readdata[15:0];
                            second_half <= direction ? flash_readdata[15:0]  : flash_readdata[31:16];
                            state       <= OUT_FIRST;
                        end
                    end
                end
                OUT_FIRST: begin
                    if (restart_pending) begin
                        flash_addr      <= restart_addr;
                        restart_pending <= 1'b0;
                        state           <= FETCH;
                    end else if (sample_tick && playing) begin
                        sample_out   <= first_half;
                        sample_valid <= 1'b1;
                        state        <= OUT_SECOND;
                    end
                end
                OUT_SECOND: begin
                    if (restart_pending) begin
                        flash_addr      <= restart_addr;
                        restart_pending <= 1'b0;
                        state           <= FETCH;
                    end else if (sample_tick && playing) begin
                        sample_out   <= second_half;
                        sample_valid <= 1'b1;
                        state        <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (restart_pending) begin
                        flash_addr      <= restart_addr;
                        restart_pending <= 1'b0;
                    end else if (!direction) begin
                        flash_addr <= (flash_addr == LAST_ADDR) ? '0 : flash_addr + ADDR_W'(1);
                    end else begin
                        flash_addr <= (flash_addr == '0) ? LAST_ADDR : flash_addr - ADDR_W'(1);
                    end
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase

            // Placed after the FSM so a new restart strobe wins over a same-cycle clear.
            if (kbd_valid) begin
                case (key_uc)
                    8'h45:   playing         <= 1'b1;
                    8'h44:   playing         <= 1'b0;
                    8'h46:   direction       <= 1'b0;
                    8'h42:   direction       <= 1'b1;
                    8'h52:   restart_pending <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Directed bench for kbd_playback_ctrl with a 2-cycle-latency flash model.
module tb_kbd_playback_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  kbd_data;
    logic        kbd_valid;
    logic        sample_tick;
    logic        flash_read;
    logic [22:0] flash_addr;
    logic        flash_waitrequest;
    logic [31:0] flash_readdata;
    logic        flash_readdatavalid;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        playing;
    logic        direction;

    int tests = 0;
    int fails = 0;

    logic        wreq  = 1'b0;
    logic        stray = 1'b0;
    logic        mdl_rdv = 1'b0;
    logic [31:0] mdl_dat = '0;
    logic        d1v = 1'b0, d2v = 1'b0;
    logic [22:0] d1a = '0, d2a = '0;
    logic [22:0] acc_log [0:63];
    int          acc_cnt = 0;
    int          exp_acc = 0;
    int          sv_cnt  = 0;
    int          sv_snap;
    logic [15:0] hold_val;

    always #5 clk = ~clk;

    assign flash_waitrequest   = wreq;
    assign flash_readdatavalid = mdl_rdv | stray;
    assign flash_readdata      = mdl_dat;

    kbd_playback_ctrl #(.ADDR_W(23), .LAST_ADDR(23'h7FFFF)) dut (
        .clk                 (clk),
        .reset               (reset),
        .kbd_data            (kbd_data),
        .kbd_valid           (kbd_valid),
        .sample_tick         (sample_tick),
        .flash_read          (flash_read),
        .flash_addr          (flash_addr),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .sample_out          (sample_out),
        .sample_valid        (sample_valid),
        .playing             (playing),
        .direction           (direction)
    );

    function automatic logic [31:0] fdata(input logic [22:0] a);
        if (a == 23'd0)      return 32'hBBBB_AAAA;
        else if (a == 23'd1) return 32'hDDDD_CCCC;
        else                 return {4'hA, a[11:0], 4'h5, a[11:0]};
    endfunction

    // Flash: accepted request at edge k returns data sampled by the DUT at edge k+2.
    always @(posedge clk) begin
        d2v = d1v;
        d2a = d1a;
        d1v = flash_read && !flash_waitrequest;
        d1a = flash_addr;
        if (d1v && acc_cnt < 64) begin
            acc_log[acc_cnt] = flash_addr;
            acc_cnt++;
        end
        #1;
        mdl_rdv = d2v;
        mdl_dat = fdata(d2a);
    end

    always @(negedge clk) if (sample_valid) sv_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [7:0] c);
        kbd_data  = c;
        kbd_valid = 1'b1;
        @(negedge clk);
        kbd_valid = 1'b0;
    endtask

    task automatic tick_expect(input string tag, input logic [15:0] exp);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check({tag, "_vld"}, {31'd0, sample_valid}, 32'd1);
        check(tag, {16'd0, sample_out}, {16'd0, exp});
    endtask

    task automatic tick_idle(input string tag, input logic [15:0] held);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check({tag, "_vld"}, {31'd0, sample_valid}, 32'd0);
        check(tag, {16'd0, sample_out}, {16'd0, held});
    endtask

    // Waits for the next accepted read, checks its address, then lets the word reach OUT_FIRST.
    task automatic wait_word(input string tag, input logic [22:0] exp_addr);
        exp_acc++;
        for (int i = 0; i < 60 && acc_cnt < exp_acc; i++) @(negedge clk);
        if (acc_cnt < exp_acc) check({tag, "_timeout"}, acc_cnt, exp_acc);
        check(tag, {9'd0, acc_log[exp_acc-1]}, {9'd0, exp_addr});
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_playing"},   {31'd0, playing},      32'd0);
        check({tag, "_direction"}, {31'd0, direction},    32'd0);
        check({tag, "_rd"},        {31'd0, flash_read},   32'd0);
        check({tag, "_addr"},      {9'd0, flash_addr},    32'd0);
        check({tag, "_sample"},    {16'd0, sample_out},   32'd0);
        check({tag, "_svld"},      {31'd0, sample_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) acc_log[i] = 'x;
        reset       = 1'b1;
        kbd_data    = 8'h00;
        kbd_valid   = 1'b0;
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // 1: basic forward playback
        reset = 1'b0;
        key("E");
        check("play_on", {31'd0, playing}, 32'd1);
        wait_word("t1_addr0", 23'd0);
        tick_expect("t1_s0", 16'hAAAA);
        tick_expect("t1_s1", 16'hBBBB);
        wait_word("t1_addr1", 23'd1);
        tick_expect("t1_s2", 16'hCCCC);
        tick_expect("t1_s3", 16'hDDDD);
        wait_word("t1_addr2", 23'd2);
        check("t1_svcnt", sv_cnt, 32'd4);

        // 2: wrap forward at LAST_ADDR, then backward wrap at 0
        key("B");
        key("R");
        key("F");
        wait_word("t2_restart_last", 23'h7FFFF);
        check("t2_dir_fwd", {31'd0, direction}, 32'd0);
        tick_expect("t2_last_lo", 16'h5FFF);
        tick_expect("t2_last_hi", 16'hAFFF);
        wait_word("t2_wrap0", 23'd0);
        key("b");
        check("t2_dir_bwd", {31'd0, direction}, 32'd1);
        tick_expect("t2_w0_lo", 16'hAAAA);
        tick_expect("t2_w0_hi", 16'hBBBB);
        wait_word("t2_wrap_last", 23'h7FFFF);
        tick_expect("t2_bwd_hi", 16'hAFFF);
        tick_expect("t2_bwd_lo", 16'h5FFF);
        wait_word("t2_dec", 23'h7FFFE);

        // 5: 'F' together with a tick in OUT_FIRST while backward
        kbd_data    = "F";
        kbd_valid   = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        kbd_valid   = 1'b0;
        sample_tick = 1'b0;
        check("t5_vld", {31'd0, sample_valid}, 32'd1);
        check("t5_s0", {16'd0, sample_out}, 32'h0000_AFFE);
        check("t5_dir", {31'd0, direction}, 32'd0);
        tick_expect("t5_s1", 16'h5FFE);
        wait_word("t5_inc", 23'h7FFFF);

        // 3: pause mid-word, resume with the second half
        tick_expect("t3_s0", 16'h5FFF);
        key("D");
        check("t3_paused", {31'd0, playing}, 32'd0);
        sv_snap = sv_cnt;
        tick_idle("t3_idle0", 16'h5FFF);
        tick_idle("t3_idle1", 16'h5FFF);
        check("t3_svcnt", sv_cnt, sv_snap);
        key("e");
        tick_expect("t3_resume", 16'hAFFF);

        // 4: restart while the flash stalls the read of addr 5
        for (int a = 0; a < 5; a++) begin
            wait_word("t4_addr", 23'(a));
            hold_val = fdata(23'(a)) >> 0;
            tick_expect("t4_lo", hold_val);
            hold_val = fdata(23'(a)) >> 16;
            tick_expect("t4_hi", hold_val);
        end
        wreq = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_rd_stall", {31'd0, flash_read}, 32'd1);
        check("t4_addr5", {9'd0, flash_addr}, 32'd5);
        key("R");
        repeat (3) @(negedge clk);
        check("t4_rd_held", {31'd0, flash_read}, 32'd1);
        check("t4_addr5_held", {9'd0, flash_addr}, 32'd5);
        sv_snap = sv_cnt;
        wreq = 1'b0;
        wait_word("t4_acc5", 23'd5);
        wait_word("t4_restart0", 23'd0);
        check("t4_discard", sv_cnt, sv_snap);

        // 6: reset during WAIT_DATA with a stray readdatavalid afterwards
        key("B");
        tick_expect("t6_s0", 16'hAAAA);
        tick_expect("t6_s1", 16'hBBBB);
        exp_acc++;
        for (int i = 0; i < 60 && acc_cnt < exp_acc; i++) @(negedge clk);
        if (acc_cnt < exp_acc) check("t6_acc_timeout", acc_cnt, exp_acc);
        check("t6_addr_last", {9'd0, acc_log[exp_acc-1]}, 32'h0007_FFFF);
        reset = 1'b1;
        wreq  = 1'b1;
        @(negedge clk);
        check_reset_vals("t6_rst");
        reset   = 1'b0;
        sv_snap = sv_cnt;
        repeat (2) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        check("t6_no_svld", sv_cnt, sv_snap);
        check("t6_sample_hold", {16'd0, sample_out}, 32'd0);
        check("t6_rd_reissue", {31'd0, flash_read}, 32'd1);
        check("t6_addr_reissue", {9'd0, flash_addr}, 32'd0);
        wreq = 1'b0;
        wait_word("t6_acc0", 23'd0);
        check("t6_still_paused", {31'd0, playing}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
